memory_interface: RTL and testbench

- Sits directly downstream of the multicycle controller and the load/store data paths. Turns single-transfer core requests (memory_enable/memory_command, with memory_ready/memory_valid back to the core) into a valid/ready request channel and a valid response channel on the system bus.
- Produces memory_ready, memory_valid, the misaligned_exception check, and the raw read word consumed by the instruction register and the load decoder.
- Adds byte-strobe generation and a response timeout that reports an access fault.

---
 rtl/memory_interface.sv | 133 +++++++++++++
 tb/tb_memory_interface.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_interface.sv
// Bridges single-transfer core requests onto a valid/ready bus request channel
// and a one-cycle response channel, with byte strobes and a response timeout.
module memory_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNTER_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] address,
  input  logic [1:0]  access_size,
  input  logic [31:0] write_data,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic        access_fault,
  output logic        misaligned_exception,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_error
);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESPONSE, RESPOND} state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] count;
  logic [3:0]               strobe;
  logic                     timeout_hit;

  always_comb begin
    misaligned_exception = 1'b0;
    unique case (access_size)
      2'b01:   misaligned_exception = address[0];
      2'b10:   misaligned_exception = (address[1:0] != 2'b00);
      2'b11:   misaligned_exception = 1'b1;
      default: misaligned_exception = 1'b0;
    endcase
  end

  always_comb begin
    strobe = 4'b1111;
    unique case (access_size)
      2'b00:   strobe = 4'b0001 << address[1:0];
      2'b01:   strobe = 4'b0011 << {address[1], 1'b0};
      default: strobe = 4'b1111;
    endcase
  end

  // A zero TIMEOUT_CYCLES disables the fault path entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (count == COUNTER_WIDTH'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      memory_ready  <= 1'b1;
      memory_valid  <= 1'b0;
      access_fault  <= 1'b0;
      read_data     <= '0;
      bus_req_valid <= 1'b0;
      bus_req_write <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
    end else begin
      memory_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (memory_enable && !misaligned_exception) begin
            bus_req_write <= memory_command;
            bus_req_addr  <= {address[31:2], 2'b00};
            bus_req_wdata <= write_data;
            bus_req_wstrb <= memory_command ? strobe : 4'b0000;
            bus_req_valid <= 1'b1;
            memory_ready  <= 1'b0;
            count         <= '0;
            state         <= REQUEST;
          end
        end
        REQUEST: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            count         <= '0;
            state         <= WAIT_RESPONSE;
          end else if (timeout_hit) begin
            bus_req_valid <= 1'b0;
            access_fault  <= 1'b1;
            read_data     <= '0;
            memory_valid  <= 1'b1;
            state         <= RESPOND;
          end else if (count != {COUNTER_WIDTH{1'b1}}) begin
            count <= count + COUNTER_WIDTH'(1);
          end
        end
        WAIT_RESPONSE: begin
          // A response arriving on the timeout cycle still takes precedence.
          if (bus_rsp_valid) begin
            read_data    <= bus_rsp_rdata;
            access_fault <= bus_rsp_error;
            memory_valid <= 1'b1;
            state        <= RESPOND;
          end else if (timeout_hit) begin
            access_fault <= 1'b1;
            read_data    <= '0;
            memory_valid <= 1'b1;
            state        <= RESPOND;
          end else if (count != {COUNTER_WIDTH{1'b1}}) begin
            count <= count + COUNTER_WIDTH'(1);
          end
        end
        RESPOND: begin
          access_fault <= 1'b0;
          memory_ready <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state         <= IDLE;
          memory_ready  <= 1'b1;
          bus_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: directed vector table, reset corner cases and
// randomized transfers against a transaction-level reference model.
module tb_memory_interface;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_enable = 1'b0;
  logic        memory_command = 1'b0;
  logic [31:0] address = '0;
  logic [1:0]  access_size = '0;
  logic [31:0] write_data = '0;
  logic        bus_req_ready = 1'b0;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic        bus_rsp_error = 1'b0;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        fault;
    logic        mis;
    logic        rv;
    logic        rw;
    logic [31:0] raddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } out_t;

  logic        a_ready, a_valid, a_fault, a_mis, a_rv, a_rw;
  logic [31:0] a_rdata, a_raddr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        b_ready, b_valid, b_fault, b_mis, b_rv, b_rw;
  logic [31:0] b_rdata, b_raddr, b_wdata;
  logic [3:0]  b_wstrb;
  out_t        oa, ob, o;
  logic        sel = 1'b0;

  memory_interface dut (
    .clk(clk), .reset(reset), .memory_enable(memory_enable),
    .memory_command(memory_command), .address(address), .access_size(access_size),
    .write_data(write_data), .memory_ready(a_ready), .memory_valid(a_valid),
    .read_data(a_rdata), .access_fault(a_fault), .misaligned_exception(a_mis),
    .bus_req_valid(a_rv), .bus_req_ready(bus_req_ready), .bus_req_write(a_rw),
    .bus_req_addr(a_raddr), .bus_req_wdata(a_wdata), .bus_req_wstrb(a_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .bus_rsp_error(bus_rsp_error)
  );

  memory_interface #(.TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)) dut_to (
    .clk(clk), .reset(reset), .memory_enable(memory_enable),
    .memory_command(memory_command), .address(address), .access_size(access_size),
    .write_data(write_data), .memory_ready(b_ready), .memory_valid(b_valid),
    .read_data(b_rdata), .access_fault(b_fault), .misaligned_exception(b_mis),
    .bus_req_valid(b_rv), .bus_req_ready(bus_req_ready), .bus_req_write(b_rw),
    .bus_req_addr(b_raddr), .bus_req_wdata(b_wdata), .bus_req_wstrb(b_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .bus_rsp_error(bus_rsp_error)
  );

  assign oa = {a_ready, a_valid, a_rdata, a_fault, a_mis, a_rv, a_rw, a_raddr, a_wdata, a_wstrb};
  assign ob = {b_ready, b_valid, b_rdata, b_fault, b_mis, b_rv, b_rw, b_raddr, b_wdata, b_wstrb};
  assign o  = sel ? ob : oa;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        cmd;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          dr;
    int          ds;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic        e_fault;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_reqc;
  } txn_t;

  // Transaction-level model: alignment rules, strobe from byte count and
  // offset, and completion time from the ready/response delays and timeout.
  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic txn_t model(input txn_t s, input int t_lim);
    txn_t m = s;
    int nbytes = (s.size == 2'd0) ? 1 : (s.size == 2'd1) ? 2 : 4;
    m.mis     = model_mis(s.addr, s.size);
    m.e_addr  = s.addr - (s.addr % 4);
    m.e_wstrb = s.cmd ? 4'(((1 << nbytes) - 1) << (s.addr % 4)) : 4'd0;
    if (t_lim != 0 && s.dr > t_lim) begin
      m.e_fault = 1'b1; m.e_rdata = '0; m.e_lat = t_lim + 2; m.e_reqc = t_lim + 1;
    end else if (t_lim != 0 && s.ds > t_lim) begin
      m.e_fault = 1'b1; m.e_rdata = '0; m.e_lat = s.dr + t_lim + 3; m.e_reqc = s.dr + 1;
    end else begin
      m.e_fault = s.err; m.e_rdata = s.rdata; m.e_lat = s.dr + s.ds + 3; m.e_reqc = s.dr + 1;
    end
    return m;
  endfunction

  task automatic run_mis(input txn_t t);
    int bad = 0;
    sel = t.sel;
    @(negedge clk);
    memory_enable = 1'b1; memory_command = t.cmd; address = t.addr;
    access_size = t.size; write_data = t.wdata;
    #1 check($sformatf("mis_flag@%0h/%0d", t.addr, t.size), o.mis, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      memory_enable = 1'b0;
      if (o.rv || !o.ready || o.valid) bad++;
    end
    check($sformatf("mis_no_req@%0h", t.addr), bad, 0);
  endtask

  task automatic run_txn(input txn_t t);
    int first = -1, pulses = 0, reqc = 0, field_bad = 0, ready_bad = 0, last;
    logic [31:0] got_rdata = '0;
    logic        got_fault = 1'b0;
    if (t.mis) begin
      run_mis(t);
      return;
    end
    sel  = t.sel;
    last = ((t.e_lat > 2 + t.dr + t.ds) ? t.e_lat : 2 + t.dr + t.ds) + 2;
    @(negedge clk);
    memory_enable = 1'b1; memory_command = t.cmd; address = t.addr;
    access_size = t.size; write_data = t.wdata;
    #1 check($sformatf("mis_clear@%0h", t.addr), o.mis, 1'b0);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        memory_enable = 1'b0;
        address = $urandom; access_size = 2'($urandom); write_data = $urandom;
        memory_command = 1'($urandom);
      end
      if (o.valid) begin
        pulses++;
        if (first < 0) begin first = k; got_rdata = o.rdata; got_fault = o.fault; end
      end
      if (o.rv) begin
        reqc++;
        if (o.raddr !== t.e_addr || o.wstrb !== t.e_wstrb || o.rw !== t.cmd ||
            o.wdata !== t.wdata) field_bad++;
      end
      if (o.ready !== (k > t.e_lat)) ready_bad++;
      bus_req_ready = (k == 1 + t.dr);
      bus_rsp_valid = (k == 2 + t.dr + t.ds);
      bus_rsp_rdata = bus_rsp_valid ? t.rdata : $urandom;
      bus_rsp_error = bus_rsp_valid ? t.err : 1'($urandom);
    end
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    check($sformatf("latency@%0h", t.addr), first, t.e_lat);
    check($sformatf("single_pulse@%0h", t.addr), pulses, 1);
    check($sformatf("fault@%0h", t.addr), got_fault, t.e_fault);
    check($sformatf("rdata@%0h", t.addr), got_rdata, t.e_rdata);
    check($sformatf("req_cycles@%0h", t.addr), reqc, t.e_reqc);
    check($sformatf("req_fields@%0h", t.addr), field_bad, 0);
    check($sformatf("ready_window@%0h", t.addr), ready_bad, 0);
  endtask

  task automatic reset_midflight(input txn_t follow);
    int pulses = 0;
    sel = 1'b0;
    @(negedge clk);
    memory_enable = 1'b1; memory_command = 1'b0; address = 32'h500; access_size = 2'd2;
    @(negedge clk);
    memory_enable = 1'b0;
    check("rst_req_active", o.rv, 1'b1);
    #2 reset = 1'b0;
    #1 check("rst_req_drop", {o.rv, o.ready, o.raddr}, {1'b0, 1'b1, 32'h0});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    memory_enable = 1'b1; address = 32'h504;
    @(negedge clk);
    memory_enable = 1'b0; bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    check("rst_in_wait", {o.rv, o.ready}, 2'b00);
    #3 reset = 1'b0;
    #1 check("rst_wait_ready", {o.rv, o.ready, o.valid}, 3'b010);
    @(negedge clk);
    reset = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h5555_5555;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_rsp_valid = 1'b0;
      if (o.valid) pulses++;
    end
    check("stale_rsp_ignored", pulses, 0);
    run_txn(follow);
  endtask

  txn_t tbl[15];

  initial begin
    //        sel   cmd   addr          sz    wdata          dr ds rdata         err   mis   e_addr        strb   flt   e_rdata       lat reqc
    tbl[0]  = '{1'b0, 1'b0, 32'h100, 2'd2, 32'h0,        0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h100, 4'h0, 1'b0, 32'hDEADBEEF, 3, 1};
    tbl[1]  = '{1'b0, 1'b1, 32'h203, 2'd0, 32'hAA000000, 5, 1, 32'h0,        1'b0, 1'b0, 32'h200, 4'h8, 1'b0, 32'h0,        9, 6};
    tbl[2]  = '{1'b0, 1'b0, 32'h101, 2'd1, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 32'h0,   4'h0, 1'b0, 32'h0,        0, 0};
    tbl[3]  = '{1'b0, 1'b0, 32'h102, 2'd2, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 32'h0,   4'h0, 1'b0, 32'h0,        0, 0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,   2'd3, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 32'h0,   4'h0, 1'b0, 32'h0,        0, 0};
    tbl[5]  = '{1'b0, 1'b1, 32'h102, 2'd1, 32'h55660000, 0, 0, 32'h0,        1'b0, 1'b0, 32'h100, 4'hC, 1'b0, 32'h0,        3, 1};
    tbl[6]  = '{1'b0, 1'b0, 32'h40,  2'd2, 32'h0,        1, 2, 32'h1234,     1'b1, 1'b0, 32'h40,  4'h0, 1'b1, 32'h1234,     6, 2};
    tbl[7]  = '{1'b0, 1'b1, 32'h1,   2'd0, 32'h0000BB00, 0, 3, 32'h0,        1'b0, 1'b0, 32'h0,   4'h2, 1'b0, 32'h0,        6, 1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,   2'd1, 32'h00001122, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,   4'h3, 1'b0, 32'h0,        3, 1};
    tbl[9]  = '{1'b0, 1'b1, 32'h10,  2'd2, 32'h12345678, 2, 0, 32'h0,        1'b0, 1'b0, 32'h10,  4'hF, 1'b0, 32'h0,        5, 3};
    tbl[10] = '{1'b1, 1'b0, 32'h300, 2'd2, 32'h0,        0, 9, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h300, 4'h0, 1'b1, 32'h0,        7, 1};
    tbl[11] = '{1'b1, 1'b0, 32'h304, 2'd2, 32'h0,        0, 4, 32'hCAFE0001, 1'b0, 1'b0, 32'h304, 4'h0, 1'b0, 32'hCAFE0001, 7, 1};
    tbl[12] = '{1'b1, 1'b1, 32'h308, 2'd2, 32'hDEAD0000, 6, 0, 32'hABCD,     1'b0, 1'b0, 32'h308, 4'hF, 1'b1, 32'h0,        6, 5};
    tbl[13] = '{1'b1, 1'b0, 32'h30C, 2'd2, 32'h0,        4, 0, 32'h77,       1'b0, 1'b0, 32'h30C, 4'h0, 1'b0, 32'h77,       7, 5};
    tbl[14] = '{1'b1, 1'b0, 32'h312, 2'd0, 32'h0,        0, 0, 32'h11223344, 1'b0, 1'b0, 32'h310, 4'h0, 1'b0, 32'h11223344, 3, 1};

    repeat (2) @(negedge clk);
    check("reset_ctrl", {oa.ready, oa.valid, oa.fault, oa.rv, oa.rw, ob.ready, ob.rv},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("reset_data", {oa.rdata, oa.raddr, oa.wdata, oa.wstrb}, 100'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_txn(tbl[i]);

    reset_midflight(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      txn_t r;
      r.sel   = 1'b1;
      r.cmd   = 1'($urandom);
      r.addr  = {20'h0, 12'($urandom)};
      r.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r.wdata = $urandom;
      r.dr    = $urandom_range(0, 6);
      r.ds    = $urandom_range(0, 6);
      r.rdata = $urandom;
      r.err   = ($urandom_range(0, 3) == 0);
      run_txn(model(r, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
